// File: rtl/param_register_file.sv
// param_register_file: parametrised register file with two combinational read
// ports, one synchronous write port, an optional hardwired-zero entry 0 and a
// clear sequencer that zeroes every entry after reset or on request.
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding of WD3 to
// a read port whose address matches a write that will commit on this edge).
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic              clr,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } stateType;

    stateType          state;
    stateType          nextState;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] nextCnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              writeOk;

    assign busy = (state == CLEAR);

    // A write commits only when idle, not being overridden by a clear request,
    // and not aimed at the hardwired zero entry.
    assign writeOk = WE3 && !busy && !clr && !((ZERO_REG != 0) && (A3 == '0));

    // State and clear-counter register; reset restarts the clear sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // Next-state logic: walk cnt through every entry, restart on clr, and
    // leave CLEAR on the edge that zeroes the last entry.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        case (state)
            IDLE: begin
                nextCnt = '0;
                if (clr) begin
                    nextState = CLEAR;
                end
            end
            CLEAR: begin
                if (clr) begin
                    nextCnt = '0;
                end else if (cnt == LAST) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end else begin
                    nextCnt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                nextState = CLEAR;
                nextCnt   = '0;
            end
        endcase
    end

    // Storage array has no reset; the sequencer zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (writeOk) begin
            mem[A3] <= WD3;
        end
    end

    // Registered pulse flagging a write request that was thrown away because
    // a clear was running or being requested on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= WE3 && (busy || clr);
        end
    end

    // Combinational reads; busy masking and the zero entry override any data.
    always_comb begin
        RD1 = mem[A1];
        RD2 = mem[A2];
`ifdef REGFILE_BYPASS_EN
        if (writeOk && (A3 == A1)) begin
            RD1 = WD3;
        end
        if (writeOk && (A3 == A2)) begin
            RD2 = WD3;
        end
`else
`endif
        if ((ZERO_REG != 0) && (A1 == '0)) begin
            RD1 = '0;
        end
        if ((ZERO_REG != 0) && (A2 == '0)) begin
            RD2 = '0;
        end
        if (busy) begin
            RD1 = '0;
            RD2 = '0;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: drives two instances (ZERO_REG=1 and ZERO_REG=0)
// with identical stimulus and compares them against an array-based model of
// the register file with a "clear edges remaining" counter.
module tb_param_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we3;
    logic        clr;

    logic [31:0] rd1Z;
    logic [31:0] rd2Z;
    logic        busyZ;
    logic        dropZ;
    logic [31:0] rd1N;
    logic [31:0] rd2N;
    logic        busyN;
    logic        dropN;

    int testCount;
    int failCount;

    // Reference model state
    logic [31:0] memZ [32];
    logic [31:0] memN [32];
    int          clearLeft;
    logic        dropExp;

    param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .A1(a1), .A2(a2), .RD1(rd1Z), .RD2(rd2Z),
        .A3(a3), .WD3(wd3), .WE3(we3),
        .clr(clr), .busy(busyZ), .wr_drop(dropZ)
    );

    param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dutPlain (
        .clk(clk), .reset(reset),
        .A1(a1), .A2(a2), .RD1(rd1N), .RD2(rd2N),
        .A3(a3), .WD3(wd3), .WE3(we3),
        .clr(clr), .busy(busyN), .wr_drop(dropN)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected read value for a port, from the model and the current inputs
    function automatic logic [31:0] expRead(input bit zeroReg, input logic [4:0] addr);
        if (clearLeft > 0) return 32'h0;
        if (zeroReg && addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we3 && !clr && !(zeroReg && a3 == 5'd0) && a3 == addr) return wd3;
`endif
        return zeroReg ? memZ[addr] : memN[addr];
    endfunction

    // Model reaction to one rising edge, using the inputs held across it
    task automatic modelEdge();
        bit busyNow;
        busyNow = (clearLeft > 0);
        dropExp = we3 && (busyNow || clr);
        if (busyNow) begin
            if (clr) begin
                clearLeft = 32;
            end else begin
                clearLeft--;
                if (clearLeft == 0) begin
                    for (int i = 0; i < 32; i++) begin
                        memZ[i] = 32'h0;
                        memN[i] = 32'h0;
                    end
                end
            end
        end else if (clr) begin
            clearLeft = 32;
        end else if (we3) begin
            memN[a3] = wd3;
            if (a3 != 5'd0) memZ[a3] = wd3;
        end
    endtask

    // Model reaction to reset being asserted
    task automatic modelReset();
        clearLeft = 32;
        dropExp   = 1'b0;
    endtask

    // Single comparison point
    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare every output of both instances with the model
    task automatic checkOutput(input string tag);
        logic [31:0] busyExp;
        busyExp = {31'b0, clearLeft > 0};
        checkValue({tag, " rd1 zr1"}, rd1Z, expRead(1'b1, a1));
        checkValue({tag, " rd2 zr1"}, rd2Z, expRead(1'b1, a2));
        checkValue({tag, " rd1 zr0"}, rd1N, expRead(1'b0, a1));
        checkValue({tag, " rd2 zr0"}, rd2N, expRead(1'b0, a2));
        checkValue({tag, " busy zr1"}, {31'b0, busyZ}, busyExp);
        checkValue({tag, " busy zr0"}, {31'b0, busyN}, busyExp);
        checkValue({tag, " drop zr1"}, {31'b0, dropZ}, {31'b0, dropExp});
        checkValue({tag, " drop zr0"}, {31'b0, dropN}, {31'b0, dropExp});
    endtask

    // One clock cycle: drive inputs, check same-cycle reads, clock, check again
    task automatic applyStimulus(input string tag, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic c,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        we3 = we;
        a3  = wa;
        wd3 = wd;
        clr = c;
        a1  = ra1;
        a2  = ra2;
        #2;
        checkOutput({tag, " pre"});
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput({tag, " post"});
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(31 - i));
        end
    endtask

    // Busy must stay high for exactly n more edges and then fall
    task automatic expectBusyEdges(input string tag, input int n);
        int seen;
        seen = 0;
        while (busyZ === 1'b1 && seen < 40) begin
            applyStimulus(tag, 1'b0, 5'd1, 32'h0, 1'b0, 5'd1, 5'd2);
            seen++;
        end
        checkValue({tag, " busy edges"}, 32'(seen), 32'(n));
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        for (int i = 0; i < 32; i++) begin
            memZ[i] = 32'h0;
            memN[i] = 32'h0;
        end
        we3 = 1'b0; a3 = '0; wd3 = '0; clr = 1'b0; a1 = '0; a2 = '0;

        // Power-on reset
        reset = 1'b1;
        modelReset();
        #2;
        checkOutput("reset");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("reset released");

        // Initial clear takes exactly 32 edges, then every entry reads 0
        expectBusyEdges("initial clear", 32);
        idleCycles("scan after init", 32);

        // Basic write and read-back, including same-cycle behaviour
        applyStimulus("write 5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd5);
        applyStimulus("read 5", 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5);
        checkValue("rd1 addr5", rd1Z, 32'hDEADBEEF);

        // Write to entry 0: ignored with ZERO_REG=1, stored with ZERO_REG=0
        applyStimulus("write 0", 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd5);
        applyStimulus("read 0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        checkValue("zr1 entry0", rd1Z, 32'h0);
        checkValue("zr0 entry0", rd1N, 32'h1234);
        checkValue("zero write no drop", {31'b0, dropZ}, 32'h0);

        // Fill 1..31 with their index, then clear with a write during busy
        for (int i = 1; i < 32; i++) begin
            applyStimulus("fill", 1'b1, 5'(i), 32'(i), 1'b0, 5'(i - 1), 5'(i));
        end
        idleCycles("scan filled", 32);
        applyStimulus("clr pulse", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4);
        applyStimulus("write during busy", 1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd4);
        checkValue("drop during busy", {31'b0, dropZ}, 32'h1);
        expectBusyEdges("clear after fill", 31);
        idleCycles("scan after clear", 32);

        // Re-request clear at cnt=10: a fresh full sequence follows
        for (int i = 1; i < 8; i++) begin
            applyStimulus("refill", 1'b1, 5'(i), 32'(i * 3), 1'b0, 5'(i), 5'd0);
        end
        applyStimulus("clr start", 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("clear run", 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
        end
        applyStimulus("clr restart", 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2);
        expectBusyEdges("restarted clear", 32);
        idleCycles("scan after restart", 8);

        // Reset in the middle of a clear sequence
        applyStimulus("write 9", 1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd0);
        applyStimulus("clr for reset", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("pre-reset run", 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
        end
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("mid-clear reset");
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("mid-clear release");
        expectBusyEdges("clear after reset", 32);

        // clr and WE3 on the same idle edge: clear wins, write dropped
        applyStimulus("clr with write", 1'b1, 5'd7, 32'hA5, 1'b1, 5'd7, 5'd7);
        checkValue("clr+write drop", {31'b0, dropZ}, 32'h1);
        expectBusyEdges("clear after clr+write", 32);
        applyStimulus("read 7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);
        checkValue("entry7 cleared", rd1Z, 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          $urandom, ($urandom_range(0, 39) == 0),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
